// File: rtl/mc_control.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB control FSM for the MIPS-subset core.
// Define MC_INSTR_COUNT_EN to add the retired-instruction counter output InstrCnt.
module mc_control #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    output logic        PCWr,
    output logic        IRWr,
    output logic        GRFWr,
    output logic        DMWr,
    output logic [3:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic        ExtOp,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  PCSrc,
    output logic [2:0]  State,
    output logic        Illegal
`ifdef MC_INSTR_COUNT_EN
    ,
    output logic [31:0] InstrCnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_OR = 4'b0010, ALU_LUI = 4'b0011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t r_state, w_next;

    // RA_REG is consumed by the GRF write-address mux; RegDst=10 selects it.
    logic w_unused_ra;
    assign w_unused_ra = ^RA_REG;

    logic [5:0] w_op, w_fn;
    logic w_nop, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_legal;

    assign w_op    = Instr[31:26];
    assign w_fn    = Instr[5:0];
    assign w_nop   = (Instr == 32'd0);
    assign w_addu  = (w_op == OP_RTYPE) && (w_fn == FN_ADDU);
    assign w_subu  = (w_op == OP_RTYPE) && (w_fn == FN_SUBU);
    assign w_jr    = (w_op == OP_RTYPE) && (w_fn == FN_JR);
    assign w_ori   = (w_op == OP_ORI);
    assign w_lui   = (w_op == OP_LUI);
    assign w_lw    = (w_op == OP_LW);
    assign w_sw    = (w_op == OP_SW);
    assign w_beq   = (w_op == OP_BEQ);
    assign w_j     = (w_op == OP_J);
    assign w_jal   = (w_op == OP_JAL);
    assign w_legal = w_nop | w_addu | w_subu | w_jr | w_ori | w_lui | w_lw | w_sw | w_beq | w_j | w_jal;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Reset gates every output so no write can land in the reset cycle.
    always_comb begin
        w_next   = S_FETCH;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        GRFWr    = 1'b0;
        DMWr     = 1'b0;
        ALUOp    = ALU_ADD;
        ALUSrcB  = 2'b00;
        ExtOp    = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        PCSrc    = 2'b00;
        Illegal  = 1'b0;
        State    = 3'd0;
        if (!reset) begin
            State = r_state;
            case (r_state)
                S_FETCH: begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    ALUSrcB = 2'b01;
                    w_next  = S_DECODE;
                end
                S_DECODE: begin
                    if (w_j) begin
                        PCWr  = 1'b1;
                        PCSrc = 2'b10;
                    end else if (w_jr) begin
                        PCWr  = 1'b1;
                        PCSrc = 2'b11;
                    end else if (w_jal) begin
                        PCWr     = 1'b1;
                        PCSrc    = 2'b10;
                        GRFWr    = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end else if (!w_legal) begin
                        Illegal = 1'b1;
                    end else if (!w_nop) begin
                        w_next = S_EXE;
                    end
                end
                S_EXE: begin
                    w_next = S_WB;
                    if (w_addu || w_subu) begin
                        ALUOp = w_subu ? ALU_SUB : ALU_ADD;
                    end else if (w_ori) begin
                        ALUSrcB = 2'b10;
                        ALUOp   = ALU_OR;
                    end else if (w_lui) begin
                        ALUSrcB = 2'b10;
                        ALUOp   = ALU_LUI;
                    end else if (w_lw || w_sw) begin
                        ALUSrcB = 2'b10;
                        ExtOp   = 1'b1;
                        w_next  = S_MEM;
                    end else if (w_beq) begin
                        ALUOp  = ALU_SUB;
                        PCWr   = Zero;
                        PCSrc  = 2'b01;
                        w_next = S_FETCH;
                    end
                end
                S_MEM: begin
                    if (w_sw) DMWr = 1'b1;
                    else      w_next = S_WB;
                end
                S_WB: begin
                    GRFWr = 1'b1;
                    if (w_addu || w_subu) RegDst = 2'b01;
                    else if (w_lw)        MemtoReg = 2'b01;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] r_instr_cnt;

    // One count per retired instruction: every edge that lands back in FETCH.
    always_ff @(posedge clk) begin
        if (reset)
            r_instr_cnt <= 32'd0;
        else if ((r_state != S_FETCH) && (w_next == S_FETCH))
            r_instr_cnt <= r_instr_cnt + 32'd1;
    end

    assign InstrCnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expected output vectors are queued with their stimulus.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'd0;
    logic        Zero = 1'b0;
    logic        PCWr, IRWr, GRFWr, DMWr, ExtOp, Illegal;
    logic [3:0]  ALUOp;
    logic [1:0]  ALUSrcB, RegDst, MemtoReg, PCSrc;
    logic [2:0]  State;
`ifdef MC_INSTR_COUNT_EN
    logic [31:0] InstrCnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_q[$];
    logic [33:0] stim_q[$];
    logic [20:0] vF, vD;

    localparam logic [31:0] I_ADDU = 32'h00851021, I_SUBU = 32'h00851023;
    localparam logic [31:0] I_ORI = 32'h34A500FF, I_LUI = 32'h3C051234;
    localparam logic [31:0] I_LW = 32'h8D280004, I_SW = 32'hAD280004, I_BEQ = 32'h10220003;
    localparam logic [31:0] I_JAL = 32'h0C000010, I_J = 32'h08000010, I_JR = 32'h03E00008;
    localparam logic [31:0] I_ILL = 32'hFC000000;

    mc_control #(.RA_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero),
        .PCWr(PCWr), .IRWr(IRWr), .GRFWr(GRFWr), .DMWr(DMWr),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .PCSrc(PCSrc), .State(State), .Illegal(Illegal)
`ifdef MC_INSTR_COUNT_EN
        , .InstrCnt(InstrCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] pk(input logic [2:0] st, input logic pcwr, input logic irwr,
                                       input logic grfwr, input logic dmwr, input logic [3:0] op,
                                       input logic [1:0] sb, input logic ext, input logic [1:0] rd,
                                       input logic [1:0] m2r, input logic [1:0] pcs, input logic ill);
        return {st, pcwr, irwr, grfwr, dmwr, op, sb, ext, rd, m2r, pcs, ill};
    endfunction

    function automatic logic [20:0] obs();
        return {State, PCWr, IRWr, GRFWr, DMWr, ALUOp, ALUSrcB, ExtOp, RegDst, MemtoReg, PCSrc, Illegal};
    endfunction

    task automatic push(input logic r, input logic z, input logic [31:0] ins, input logic [20:0] e);
        stim_q.push_back({r, z, ins});
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [33:0] s; logic [20:0] e; int n = 0;
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, I_SW, 21'd0);
        push(1'b0, 1'b0, 32'd0, vF);
        push(1'b0, 1'b0, 32'd0, vD);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); reset = s[33]; Zero = s[32]; Instr = s[31:0]; #1;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL reset cyc %0d got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_rtype();
        logic [33:0] s; logic [20:0] e; int n = 0;
        // Zero held high throughout: it must not matter outside beq.
        push(0, 1, I_ADDU, vF); push(0, 1, I_ADDU, vD);
        push(0, 1, I_ADDU, pk(2, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        push(0, 1, I_ADDU, pk(4, 0, 0, 1, 0, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0));
        push(0, 0, I_SUBU, vF); push(0, 0, I_SUBU, vD);
        push(0, 0, I_SUBU, pk(2, 0, 0, 0, 0, 4'b0001, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_SUBU, pk(4, 0, 0, 1, 0, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); reset = s[33]; Zero = s[32]; Instr = s[31:0]; #1;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL rtype cyc %0d got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_imm();
        logic [33:0] s; logic [20:0] e; int n = 0;
        push(0, 0, I_ORI, vF); push(0, 0, I_ORI, vD);
        push(0, 0, I_ORI, pk(2, 0, 0, 0, 0, 4'b0010, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_ORI, pk(4, 0, 0, 1, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_LUI, vF); push(0, 0, I_LUI, vD);
        push(0, 0, I_LUI, pk(2, 0, 0, 0, 0, 4'b0011, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_LUI, pk(4, 0, 0, 1, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); reset = s[33]; Zero = s[32]; Instr = s[31:0]; #1;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL imm cyc %0d got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_mem();
        logic [33:0] s; logic [20:0] e; int n = 0;
        push(0, 0, I_LW, vF); push(0, 0, I_LW, vD);
        push(0, 0, I_LW, pk(2, 0, 0, 0, 0, 4'b0000, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_LW, pk(3, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_LW, pk(4, 0, 0, 1, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b01, 2'b00, 0));
        push(0, 0, I_SW, vF); push(0, 0, I_SW, vD);
        push(0, 0, I_SW, pk(2, 0, 0, 0, 0, 4'b0000, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_SW, pk(3, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); reset = s[33]; Zero = s[32]; Instr = s[31:0]; #1;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL mem cyc %0d got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_beq();
        logic [33:0] s; logic [20:0] e; int n = 0;
        push(0, 0, I_BEQ, vF); push(0, 0, I_BEQ, vD);
        push(0, 1, I_BEQ, pk(2, 1, 0, 0, 0, 4'b0001, 2'b00, 0, 2'b00, 2'b00, 2'b01, 0));
        // Not-taken: Zero high in FETCH/DECODE is ignored, low in EXE blocks the PC write.
        push(0, 1, I_BEQ, vF); push(0, 1, I_BEQ, vD);
        push(0, 0, I_BEQ, pk(2, 0, 0, 0, 0, 4'b0001, 2'b00, 0, 2'b00, 2'b00, 2'b01, 0));
        push(0, 0, 32'd0, vF); push(0, 0, 32'd0, vD);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); reset = s[33]; Zero = s[32]; Instr = s[31:0]; #1;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL beq cyc %0d got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_jump();
        logic [33:0] s; logic [20:0] e; int n = 0;
        push(0, 0, I_JAL, vF);
        push(0, 0, I_JAL, pk(1, 1, 0, 1, 0, 4'b0000, 2'b00, 0, 2'b10, 2'b10, 2'b10, 0));
        push(0, 0, I_J, vF);
        push(0, 0, I_J, pk(1, 1, 0, 0, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b10, 0));
        push(0, 0, I_JR, vF);
        push(0, 0, I_JR, pk(1, 1, 0, 0, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0));
        push(0, 0, I_ILL, vF);
        push(0, 0, I_ILL, pk(1, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1));
        push(0, 0, I_ILL, vF);
        push(0, 0, 32'd0, vD);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); reset = s[33]; Zero = s[32]; Instr = s[31:0]; #1;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL jump cyc %0d got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] s; logic [20:0] e; int n = 0;
        push(0, 0, I_SW, vF); push(0, 0, I_SW, vD);
        push(0, 0, I_SW, pk(2, 0, 0, 0, 0, 4'b0000, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0));
        push(1, 0, I_SW, 21'd0);
        push(0, 0, 32'd0, vF); push(0, 0, 32'd0, vD);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); reset = s[33]; Zero = s[32]; Instr = s[31:0]; #1;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL reset_mid cyc %0d got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

`ifdef MC_INSTR_COUNT_EN
    task automatic test_count();
        logic [33:0] s; logic [20:0] e; int n = 0;
        @(negedge clk); reset = 1'b1; Instr = 32'd0; Zero = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (InstrCnt !== 32'd0) begin
            errors++; $display("FAIL count_reset got %0d expected 0", InstrCnt);
        end
        push(0, 0, I_ADDU, vF); push(0, 0, I_ADDU, vD);
        push(0, 0, I_ADDU, pk(2, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_ADDU, pk(4, 0, 0, 1, 0, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0));
        push(0, 0, I_LW, vF); push(0, 0, I_LW, vD);
        push(0, 0, I_LW, pk(2, 0, 0, 0, 0, 4'b0000, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_LW, pk(3, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_LW, pk(4, 0, 0, 1, 0, 4'b0000, 2'b00, 0, 2'b00, 2'b01, 2'b00, 0));
        push(0, 0, I_SW, vF); push(0, 0, I_SW, vD);
        push(0, 0, I_SW, pk(2, 0, 0, 0, 0, 4'b0000, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0));
        push(0, 0, I_SW, pk(3, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); reset = s[33]; Zero = s[32]; Instr = s[31:0]; #1;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL count_seq cyc %0d got %h expected %h", n, obs(), e);
            end
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (InstrCnt !== 32'd3) begin
            errors++; $display("FAIL count_retired got %0d expected 3", InstrCnt);
        end
    endtask
`endif

    initial begin
        vF = pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        vD = pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        test_reset();
        test_rtype();
        test_imm();
        test_mem();
        test_beq();
        test_jump();
        test_reset_mid();
`ifdef MC_INSTR_COUNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
